// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto a 16-bit memory, split into one or two beats.
// Grant to ack: 3 cycles (32-bit) or 2 (16-bit); requesters hold until their ack, one transaction in flight.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [19:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_size,
  input  logic [19:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_re
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        size_q, size_d;
  logic        own_q, own_d;
  logic [1:0]  starve_q, starve_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        data_win;

  // Data normally wins; a twice-passed-over fetch gets the next slot.
  assign data_win = d_req && !((starve_q == 2'd2) && if_req);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    own_d      = own_q;
    starve_d   = starve_q;
    lo_d       = lo_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_addr   = 20'h0;
    mem_wdata  = 16'h0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d  = BEAT0;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          size_d   = d_size;
          own_d    = 1'b1;
          if (if_req && (starve_q != 2'd2)) starve_d = starve_q + 2'd1;
        end else if (if_req) begin
          state_d  = BEAT0;
          addr_d   = if_addr;
          wdata_d  = 32'h0;
          we_d     = 1'b0;
          size_d   = 1'b1;
          own_d    = 1'b0;
          starve_d = 2'd0;
        end
      end
      BEAT0: begin
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_re    = !we_q;
        mem_wdata = we_q ? wdata_q[15:0] : 16'h0;
        if (!we_q) lo_d = mem_rdata;
        if (size_q) begin
          state_d = BEAT1;
        end else begin
          state_d = DONE;
          if (!we_q && own_q) d_rdata_d = {16'h0, mem_rdata};
        end
      end
      BEAT1: begin
        mem_addr  = addr_q + 20'd1;
        mem_we    = we_q;
        mem_re    = !we_q;
        mem_wdata = we_q ? wdata_q[31:16] : 16'h0;
        state_d   = DONE;
        if (!we_q) begin
          if (own_q) d_rdata_d  = {mem_rdata, lo_q};
          else       if_rdata_d = {mem_rdata, lo_q};
        end
      end
      DONE: begin
        if_ack  = !own_q;
        d_ack   = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 20'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 1'b0;
      own_q      <= 1'b0;
      starve_q   <= 2'd0;
      lo_q       <= 16'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      own_q      <= own_d;
      starve_q   <= starve_d;
      lo_q       <= lo_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected queues checked on each ack.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, d_size;
  logic [19:0] if_addr, d_addr;
  logic [31:0] d_wdata, if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_re(mem_re)
  );

  bit [15:0] mem [0:1048575];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        exp_d[$];
  exp_t        exp_f[$];
  bit          order_obs[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          beat0_cyc = 0;
  bit          beat_prev = 1'b0;
  logic [19:0] beat0_addr = 20'h0;
  logic [19:0] beat1_exp;
  logic [31:0] d_rdata_m = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      beat_prev = 1'b0;
    end else begin
      if (mem_re || mem_we) begin
        check("we_re_exclusive", {31'h0, mem_we & mem_re}, 32'h0);
        if (!beat_prev) begin
          beat0_cyc  = cyc;
          beat0_addr = mem_addr;
        end else begin
          beat1_exp = beat0_addr + 20'd1;
          check("beat1_addr", {12'h0, mem_addr}, {12'h0, beat1_exp});
        end
        beat_prev = 1'b1;
      end else begin
        beat_prev = 1'b0;
        check("idle_mem_addr", {12'h0, mem_addr}, 32'h0);
        check("idle_mem_wdata", {16'h0, mem_wdata}, 32'h0);
      end
      check("ack_exclusive", {31'h0, if_ack & d_ack}, 32'h0);
      if (d_ack) begin
        if (exp_d.size() == 0) check("d_ack_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_d.pop_front();
          check("d_addr", {12'h0, beat0_addr}, {12'h0, e.addr});
          check("d_latency", cyc - beat0_cyc, e.lat);
          check("d_rdata", d_rdata, e.rdata);
          order_obs.push_back(1'b1);
        end
      end
      if (if_ack) begin
        if (exp_f.size() == 0) check("if_ack_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_f.pop_front();
          check("if_addr", {12'h0, beat0_addr}, {12'h0, e.addr});
          check("if_latency", cyc - beat0_cyc, e.lat);
          check("if_rdata", if_rdata, e.rdata);
          order_obs.push_back(1'b0);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic data_op(input bit we, input bit sz, input logic [19:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [19:0] a1;
    bit          got;
    a1 = a + 20'd1;
    if (!we) d_rdata_m = sz ? {mem[a1], mem[a]} : {16'h0, mem[a]};
    e.addr = a; e.rdata = d_rdata_m; e.lat = sz ? 2 : 1;
    exp_d.push_back(e);
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    check("d_ack_seen", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [19:0] a);
    exp_t        e;
    logic [19:0] a1;
    bit          got;
    a1 = a + 20'd1;
    e.addr = a; e.rdata = {mem[a1], mem[a]}; e.lat = 2;
    exp_f.push_back(e);
    if_addr = a; if_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = if_ack;
    end
    check("if_ack_seen", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_order [6];
    bit seen;
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 1'b0;
    if_addr = 20'h0; d_addr = 20'h0; d_wdata = 32'h0;
    mem[20'h00010] = 16'h1234; mem[20'h00011] = 16'hABCD;
    mem[20'hFFFFF] = 16'h5566; mem[20'h00000] = 16'h7788;
    mem[20'h00301] = 16'h0F0F;
    for (int i = 0; i < 8; i++) mem[20'(32'h400 + i)] = 16'(32'hC000 + i * 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", {31'h0, if_ack}, 32'h0);
    check("rst_d_ack", {31'h0, d_ack}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_mem_strobes", {30'h0, mem_we, mem_re}, 32'h0);
    check("rst_mem_addr", {12'h0, mem_addr}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    fetch_op(20'h00010);
    data_op(1'b1, 1'b1, 20'h00100, 32'hDEADBEEF);
    check("store_lo", {16'h0, mem[20'h00100]}, 32'h0000BEEF);
    check("store_hi", {16'h0, mem[20'h00101]}, 32'h0000DEAD);
    data_op(1'b0, 1'b0, 20'h00100, 32'h0);
    data_op(1'b0, 1'b1, 20'hFFFFF, 32'h0);
    data_op(1'b1, 1'b0, 20'h00300, 32'hAAAA5555);
    check("store16_lo", {16'h0, mem[20'h00300]}, 32'h00005555);
    check("store16_hi_untouched", {16'h0, mem[20'h00301]}, 32'h00000F0F);

    order_obs.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) data_op(1'b0, 1'b1, 20'(32'h400 + i * 2), 32'h0);
      end
      begin
        fetch_op(20'h00010);
        fetch_op(20'h00404);
      end
    join
    check("order_len", order_obs.size(), 6);
    for (int i = 0; i < 6 && i < order_obs.size(); i++)
      check($sformatf("order_%0d", i), {31'h0, order_obs[i]}, {31'h0, exp_order[i]});

    mem[20'h00200] = 16'h0; mem[20'h00201] = 16'h0;
    d_we = 1'b1; d_size = 1'b1; d_addr = 20'h00200; d_wdata = 32'h11223344; d_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_we;
    end
    check("abort_store_started", {31'h0, seen}, 32'h1);
    @(posedge clk); #2;
    reset = 1'b1; d_req = 1'b0;
    #1;
    check("abort_we_low", {31'h0, mem_we}, 32'h0);
    repeat (3) @(negedge clk);
    check("abort_d_rdata_rst", d_rdata, 32'h0);
    check("abort_lo_written", {16'h0, mem[20'h00200]}, 32'h00003344);
    check("abort_hi_unwritten", {16'h0, mem[20'h00201]}, 32'h0);
    d_rdata_m = 32'h0;
    reset = 1'b0;
    @(posedge clk); #1;
    data_op(1'b0, 1'b1, 20'h00200, 32'h0);
    check("post_reset_load", d_rdata, 32'h00003344);

    repeat (5) @(negedge clk);
    check("exp_d_drained", exp_d.size(), 0);
    check("exp_f_drained", exp_f.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 if_req  input  1  fetch request; held with if_addr stable until if_ack.
REQ-004 if_addr  input  20  fetch halfword address.
REQ-005 if_rdata  output  32  fetched word; valid with if_ack, held until next if_ack.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 d_req  input  1  data request; held with d_we, d_size, d_addr and d_wdata stable until d_ack.
REQ-008 d_we  input  1  data access type: 1 = store, 0 = load.
REQ-009 d_size  input  1  data access width: 0 = 16-bit, 1 = 32-bit.
REQ-010 d_addr  input  20  data halfword address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data; valid with d_ack, held until next d_ack.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 mem_addr  output  20  external memory halfword address.
REQ-015 mem_wdata  output  16  external write data.
REQ-016 mem_rdata  input  16  external read data, combinational from mem_addr.
REQ-017 mem_we  output  1  write strobe; memory writes on the rising edge while high.
REQ-018 mem_re  output  1  read strobe.

Function
REQ-019 FSM states SHALL be IDLE, BEAT0, BEAT1 and DONE; one transaction in flight at a time.
REQ-020 In IDLE, a pending request SHALL be granted at the clock edge; the granted request's address, data, we, size and owner SHALL be latched on that edge; next state is BEAT0.
REQ-021 Arbitration: d_req SHALL win over if_req, except when the starvation counter equals 2 and if_req is high, in which case fetch SHALL win.
REQ-022 Starvation counter (2 bits): SHALL increment on each data grant made while if_req is high, saturate at 2, and clear on any fetch grant.
REQ-023 Fetches SHALL always be 32-bit reads.
REQ-024 BEAT0: mem_addr = latched addr; store drives mem_wdata = wdata[15:0] with mem_we=1; read drives mem_re=1 and captures mem_rdata into bits [15:0] at the cycle end.
REQ-025 From BEAT0, a 32-bit access SHALL go to BEAT1; a 16-bit access SHALL go to DONE.
REQ-026 BEAT1: mem_addr = latched addr + 1, wrapping modulo 2^20 (20'hFFFFF -> 20'h00000); stores drive wdata[31:16]; reads capture mem_rdata into bits [31:16]; next state is DONE.
REQ-027 DONE: the owner's ack SHALL be high for exactly this cycle, with rdata updated to the assembled value; next state is IDLE; requests SHALL NOT be sampled in DONE.
REQ-028 A 16-bit load SHALL return {16'h0, halfword} on d_rdata.
REQ-029 A store SHALL leave d_rdata unchanged.
REQ-030 Latency from grant edge to ack cycle SHALL be 3 cycles for 32-bit accesses and 2 cycles for 16-bit accesses.
REQ-031 Outside BEAT0 and BEAT1, mem_we, mem_re, mem_addr and mem_wdata SHALL be 0.
REQ-032 mem_we and mem_re SHALL never be high together; if_ack and d_ack SHALL never be high together.

Reset
REQ-033 While reset is high: state = IDLE; all outputs 0; starvation counter 0; latched transaction cleared.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately, with no ack generated; beats whose write edges already occurred stay written, and no further beats are issued.
REQ-035 After reset deasserts, the first sampling edge in IDLE SHALL arbitrate normally.

Verification
REQ-036 Fetch: if_addr=20'h00010, mem[0x10]=16'h1234, mem[0x11]=16'hABCD -> mem_re in 2 cycles, if_ack 3 cycles after grant, if_rdata=32'hABCD1234.
REQ-037 32-bit store: d_addr=20'h00100, d_wdata=32'hDEADBEEF -> mem[0x100]=16'hBEEF, mem[0x101]=16'hDEAD, d_ack after 3 cycles, if_ack stays 0.
REQ-038 16-bit load: d_addr=20'h00100, d_size=0 -> d_ack after 2 cycles, d_rdata=32'h0000BEEF.
REQ-039 Wrap: 32-bit load at d_addr=20'hFFFFF -> BEAT1 mem_addr=20'h00000.
REQ-040 Contention: d_req and if_req held continuously -> grant order data, data, fetch, data, data, fetch.
REQ-041 Reset during BEAT1 of a 32-bit store -> low half written, high half not written, no d_ack; next request served normally.
